// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared types and default constants for the data-memory arbiter slice.
//   arb_state_t : arbiter FSM states (ARB = normal arbitration, BURST = aux holds RAM)
//   owner_t     : identifies which requester owns an access or a pending read return
//   cnt_width() : width needed for a saturating counter that must reach 'limit'
package dmem_arb_pkg;

  localparam int ADDR_W_DEF       = 12;
  localparam int DATA_W_DEF       = 32;
  localparam int BURST_MAX_DEF    = 16;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic {
    ARB,
    BURST
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_AUX
  } owner_t;

  // Bits needed to hold values 0..limit inclusive.
  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_counter.sv
// dmem_arb_counter
//   Saturating up-counter used for both the burst-length and CPU-starvation counts.
//   Ports:
//     clock  in  system clock (rising edge)
//     reset  in  asynchronous active-high reset, clears the count
//     inc    in  add one unless already at LIMIT
//     clr    in  return to zero (wins over inc)
//     sat    out count has reached LIMIT
module dmem_arb_counter
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = 4,
  parameter int WIDTH = cnt_width(LIMIT)
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count;

  assign sat = (count == LIMIT_V);

  // Count holds at LIMIT rather than wrapping so a long stall can never
  // look like a fresh start to the arbiter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port data RAM between the CPU and an auxiliary bus master
//   (loader / DMA). One access is issued per cycle; the other requester stalls.
//   The CPU wins ties by default, aux may lock bursts of up to BURST_MAX beats,
//   and a starvation counter forces a CPU grant after STARVE_LIMIT denied cycles.
//   Ports:
//     clock, reset                       clock and asynchronous active-high reset
//     cpu_req/we/addr/wdata              CPU access request
//     cpu_gnt, cpu_stall                 access issued this cycle / request waiting
//     cpu_rvalid, cpu_rdata              read return, one cycle after a read grant
//     aux_req/we/addr/wdata, aux_lock    aux access request, lock holds the RAM
//     aux_gnt, aux_rvalid, aux_rdata     as for the CPU
//     ram_wEn, ram_addr, ram_dataIn      RAM command, all zero when nothing granted
//     ram_dataOut                        registered RAM read data
//   Build option: DMEM_ARB_RR_EN makes ARB-state ties alternate between the two
//   ports (round-robin) instead of always favouring the CPU.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int BURST_MAX    = BURST_MAX_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  input  logic              aux_lock,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              ram_wEn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut
);

  arb_state_t state;
  owner_t     rd_owner;

  logic burst_sat;
  logic burst_inc;
  logic burst_clr;
  logic burst_exit;
  logic starve_sat;
  logic starve_fire;
  logic starve_inc;
  logic cpu_win;
  logic aux_win;

`ifdef DMEM_ARB_RR_EN
  // Holds the port that should win the next ARB-state tie (loser of the last one).
  owner_t last_owner;
`endif

  // Starvation only matters while the CPU is still asking.
  assign starve_fire = starve_sat & cpu_req;

  // Grant decision from requests and registered state. CPU wins ARB ties
  // (or alternates with aux in round-robin builds); in BURST aux keeps the RAM
  // unless the burst has hit its length cap or the CPU has starved.
  always_comb begin
    cpu_win = 1'b0;
    aux_win = 1'b0;
    case (state)
      ARB: begin
        if (cpu_req && aux_req) begin
`ifdef DMEM_ARB_RR_EN
          if (last_owner == OWN_AUX && !starve_fire) begin
            aux_win = 1'b1;
          end else begin
            cpu_win = 1'b1;
          end
`else
          cpu_win = 1'b1;
`endif
        end else begin
          cpu_win = cpu_req;
          aux_win = aux_req;
        end
      end
      BURST: begin
        if (starve_fire) begin
          cpu_win = 1'b1;
        end else begin
          aux_win = aux_req & ~burst_sat;
          cpu_win = cpu_req & ~aux_win;
        end
      end
      default: begin
        cpu_win = 1'b0;
        aux_win = 1'b0;
      end
    endcase
  end

  // Reset forces every output low immediately, even though grants are combinational.
  assign cpu_gnt   = cpu_win & ~reset;
  assign aux_gnt   = aux_win & ~reset;
  assign cpu_stall = cpu_req & ~cpu_gnt & ~reset;

  // Burst leaves BURST on unlock, idle aux, length cap or CPU starvation.
  assign burst_exit = ~aux_lock | ~aux_req | burst_sat | starve_fire;
  assign burst_clr  = (state == BURST) & burst_exit;
  assign burst_inc  = aux_gnt & ((state == ARB) ? aux_lock : 1'b1);

  assign starve_inc = cpu_req & ~cpu_gnt;

  dmem_arb_counter #(
    .LIMIT (BURST_MAX)
  ) u_burst_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (burst_inc),
    .clr   (burst_clr),
    .sat   (burst_sat)
  );

  dmem_arb_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (starve_inc),
    .clr   (~starve_inc),
    .sat   (starve_sat)
  );

  // FSM state, pending read owner and (optionally) the round-robin pointer.
  // A read granted on a state transition still records its owner so the
  // data returns normally the following cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ARB;
      rd_owner <= OWN_NONE;
`ifdef DMEM_ARB_RR_EN
      last_owner <= OWN_CPU;
`endif
    end else begin
      case (state)
        ARB:     if (aux_gnt && aux_lock) state <= BURST;
        BURST:   if (burst_exit) state <= ARB;
        default: state <= ARB;
      endcase

      if (cpu_gnt && !cpu_we) begin
        rd_owner <= OWN_CPU;
      end else if (aux_gnt && !aux_we) begin
        rd_owner <= OWN_AUX;
      end else begin
        rd_owner <= OWN_NONE;
      end

`ifdef DMEM_ARB_RR_EN
      if (state == ARB && cpu_req && aux_req) begin
        last_owner <= cpu_gnt ? OWN_AUX : OWN_CPU;
      end
`endif
    end
  end

  // RAM command comes from whichever port holds the grant; idle cycles drive zero.
  always_comb begin
    ram_wEn    = 1'b0;
    ram_addr   = '0;
    ram_dataIn = '0;
    if (cpu_gnt) begin
      ram_wEn    = cpu_we;
      ram_addr   = cpu_addr;
      ram_dataIn = cpu_wdata;
    end else if (aux_gnt) begin
      ram_wEn    = aux_we;
      ram_addr   = aux_addr;
      ram_dataIn = aux_wdata;
    end
  end

  assign cpu_rvalid = (rd_owner == OWN_CPU);
  assign aux_rvalid = (rd_owner == OWN_AUX);
  assign cpu_rdata  = cpu_rvalid ? ram_dataOut : '0;
  assign aux_rdata  = aux_rvalid ? ram_dataOut : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter with a behavioural registered RAM.
//   Single-cycle vectors come from a table; bursts, starvation and reset are
//   hand-written sequences. Read returns are tracked by a scoreboard queue.
module tb_dmem_arbiter;

  logic        clock;
  logic        reset;
  logic        cpu_req, cpu_we, aux_req, aux_we, aux_lock;
  logic [11:0] cpu_addr, aux_addr;
  logic [31:0] cpu_wdata, aux_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        aux_gnt, aux_rvalid;
  logic [31:0] aux_rdata;
  logic        ram_wEn;
  logic [11:0] ram_addr;
  logic [31:0] ram_dataIn, ram_dataOut;

  typedef struct {
    string       name;
    bit          cpuReq, cpuWe;
    logic [11:0] cpuAddr;
    logic [31:0] cpuWdata;
    bit          auxReq, auxLock, auxWe;
    logic [11:0] auxAddr;
    logic [31:0] auxWdata;
    bit          expCpuGnt, expAuxGnt;
  } vec_t;

  typedef struct {
    int          cyc;
    bit          isCpu;
    logic [31:0] data;
  } sb_t;

  logic [31:0] mem    [4096];
  logic [31:0] shadow [4096];
  sb_t         sb[$];
  sb_t         sbEntry;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          monOn = 0;
  logic        expC, expA;
  logic [31:0] expD;

  dmem_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_gnt     (cpu_gnt),
    .cpu_stall   (cpu_stall),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .aux_req     (aux_req),
    .aux_we      (aux_we),
    .aux_addr    (aux_addr),
    .aux_wdata   (aux_wdata),
    .aux_lock    (aux_lock),
    .aux_gnt     (aux_gnt),
    .aux_rvalid  (aux_rvalid),
    .aux_rdata   (aux_rdata),
    .ram_wEn     (ram_wEn),
    .ram_addr    (ram_addr),
    .ram_dataIn  (ram_dataIn),
    .ram_dataOut (ram_dataOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Registered single-port RAM: read data appears the cycle after the address.
  always @(posedge clock) begin
    if (ram_wEn) mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= mem[ram_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input int cr, input int cw, input int ca,
                              input logic [31:0] cd, input int ar, input int al, input int aw,
                              input int aa, input logic [31:0] ad, input int ec, input int ea);
    vec_t v;
    v.name = n;
    v.cpuReq = (cr != 0);  v.cpuWe = (cw != 0);  v.cpuAddr = 12'(ca);  v.cpuWdata = cd;
    v.auxReq = (ar != 0);  v.auxLock = (al != 0); v.auxWe = (aw != 0);
    v.auxAddr = 12'(aa);   v.auxWdata = ad;
    v.expCpuGnt = (ec != 0); v.expAuxGnt = (ea != 0);
    return v;
  endfunction

  // Drives one cycle of inputs, checks grant/stall/RAM command mid-cycle and
  // records the expected effect (RAM write or read return) in the model.
  task automatic applyStimulus(input vec_t v);
    logic        ew;
    logic [11:0] ea;
    logic [31:0] ed;
    cpu_req = v.cpuReq; cpu_we = v.cpuWe; cpu_addr = v.cpuAddr; cpu_wdata = v.cpuWdata;
    aux_req = v.auxReq; aux_lock = v.auxLock; aux_we = v.auxWe;
    aux_addr = v.auxAddr; aux_wdata = v.auxWdata;
    @(negedge clock);
    ew = 1'b0; ea = '0; ed = '0;
    if (v.expCpuGnt) begin
      ew = v.cpuWe; ea = v.cpuAddr; ed = v.cpuWdata;
    end else if (v.expAuxGnt) begin
      ew = v.auxWe; ea = v.auxAddr; ed = v.auxWdata;
    end
    checkOutput({v.name, " cpu_gnt"},    cpu_gnt,    v.expCpuGnt);
    checkOutput({v.name, " aux_gnt"},    aux_gnt,    v.expAuxGnt);
    checkOutput({v.name, " cpu_stall"},  cpu_stall,  v.cpuReq & ~v.expCpuGnt);
    checkOutput({v.name, " ram_wEn"},    ram_wEn,    ew);
    checkOutput({v.name, " ram_addr"},   ram_addr,   ea);
    checkOutput({v.name, " ram_dataIn"}, ram_dataIn, ed);
    if (v.expCpuGnt || v.expAuxGnt) begin
      if (ew) shadow[ea] = ed;
      else sb.push_back('{cyc: cyc + 1, isCpu: v.expCpuGnt, data: shadow[ea]});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic checkZero(input string name);
    checkOutput({name, " cpu_gnt"},    cpu_gnt,    0);
    checkOutput({name, " aux_gnt"},    aux_gnt,    0);
    checkOutput({name, " cpu_stall"},  cpu_stall,  0);
    checkOutput({name, " ram_wEn"},    ram_wEn,    0);
    checkOutput({name, " ram_addr"},   ram_addr,   0);
    checkOutput({name, " ram_dataIn"}, ram_dataIn, 0);
  endtask

  // Read-return monitor: every cycle, rvalid/rdata must match the scoreboard
  // entry due this cycle, or be zero when nothing is due.
  always @(negedge clock) begin
    if (monOn) begin
      expC = 1'b0; expA = 1'b0; expD = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        sbEntry = sb.pop_front();
        if (sbEntry.isCpu) expC = 1'b1;
        else expA = 1'b1;
        expD = sbEntry.data;
      end
      checkOutput("cpu_rvalid", cpu_rvalid, expC);
      checkOutput("cpu_rdata",  cpu_rdata,  expC ? expD : 32'h0);
      checkOutput("aux_rvalid", aux_rvalid, expA);
      checkOutput("aux_rdata",  aux_rdata,  expA ? expD : 32'h0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t tbl[12];
  vec_t v;
  int   idx;
  bit   expG, cr, ar, ec;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]    = 32'h5A000000 | 32'(i);
      shadow[i] = mem[i];
    end
    mem[16] = 32'hDEADBEEF;
    shadow[16] = 32'hDEADBEEF;

    // Table: all rows start and stay in ARB (no lock).
    tbl[0]  = mk("t1_cpu_rd", 1,0,'h010,0,          0,0,0,0,0,           1,0);
    tbl[1]  = mk("idle",      0,0,0,0,              0,0,0,0,0,           0,0);
    tbl[2]  = mk("aux_rd",    0,0,0,0,              1,0,0,'h020,0,       0,1);
    tbl[3]  = mk("cpu_wr",    1,1,'h030,32'h11112222, 0,0,0,0,0,         1,0);
    tbl[4]  = mk("aux_wr",    0,0,0,0,              1,0,1,'h040,32'h33334444, 0,1);
    tbl[5]  = mk("tie1",      1,0,'h040,0,          1,0,0,'h030,0,       1,0);
    tbl[6]  = mk("aux_after", 0,0,0,0,              1,0,0,'h030,0,       0,1);
`ifdef DMEM_ARB_RR_EN
    tbl[7]  = mk("tie2",      1,0,'h030,0,          1,0,1,'h050,32'h55556666, 0,1);
`else
    tbl[7]  = mk("tie2",      1,0,'h030,0,          1,0,1,'h050,32'h55556666, 1,0);
`endif
    tbl[8]  = mk("aux_wr2",   0,0,0,0,              1,0,1,'h050,32'h55556666, 0,1);
    tbl[9]  = mk("cpu_rd2",   1,0,'h050,0,          0,0,0,0,0,           1,0);
    tbl[10] = mk("tie3",      1,1,'h060,32'h77778888, 1,0,0,'h010,0,     1,0);
    tbl[11] = mk("idle2",     0,0,0,0,              0,0,0,0,0,           0,0);

    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    aux_req = 0; aux_we = 0; aux_lock = 0; aux_addr = '0; aux_wdata = '0;
    reset = 1'b0;
    #2 reset = 1'b1;
    monOn = 1'b1;
    cpu_req = 1; cpu_addr = 12'h0AB; cpu_wdata = 32'hFFFF0000;
    aux_req = 1; aux_addr = 12'h0CD; aux_wdata = 32'h0000FFFF; aux_we = 1;
    @(negedge clock);
    checkZero("rst_init");
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < 12; i++) applyStimulus(tbl[i]);

    // Locked burst of 20 writes: 16 beats, one forced-release gap, then 4 more.
    $display("[TB] burst length cap");
    idx = 0;
    for (int k = 0; k < 21; k++) begin
      expG = (k != 16);
      v = mk("t3_burst", 0,0,0,0, 1,1,1, 'h100 + idx, 32'hC0DE0000 + 32'(idx), 0, expG ? 1 : 0);
      applyStimulus(v);
      if (expG) idx++;
    end
    applyStimulus(mk("t3_end", 0,0,0,0, 0,0,0,0,0, 0,0));
    for (int i = 0; i < 20; i++)
      checkOutput("t3_ram_word", mem[12'h100 + 12'(i)], 32'hC0DE0000 + 32'(i));

    // Starvation: CPU raised on beat 3 stalls 4 cycles then wins; repeated
    // after re-entering BURST to show the starve count was cleared.
    $display("[TB] starvation abort");
    idx = 0;
    for (int k = 0; k < 14; k++) begin
      cr = (k >= 2 && k <= 6) || (k >= 8 && k <= 12);
      ar = (k <= 12);
      ec = (k == 6) || (k == 12);
      v = mk("t4_starve", cr, 0, 'h010, 0, ar, ar, 1, 'h200 + idx, 32'hB0000000 + 32'(idx),
             ec, (ar && !ec) ? 1 : 0);
      applyStimulus(v);
      if (ar && !ec) idx++;
    end

    // Reset the cycle after a CPU read grant: the return must never appear.
    $display("[TB] reset during read and burst");
    applyStimulus(mk("t5_rd", 1,0,'h010,0, 0,0,0,0,0, 1,0));
    void'(sb.pop_back());
    reset = 1'b1;
    cpu_req = 1; cpu_addr = 12'h123; cpu_wdata = 32'h12345678; aux_req = 1; aux_lock = 1;
    @(negedge clock);
    checkZero("t5_rst_rd");
    @(posedge clock); #1;
    reset = 1'b0;
    applyStimulus(mk("t5_idle", 0,0,0,0, 0,0,0,0,0, 0,0));

    // Reset mid-burst: afterwards a tie must go to the CPU, proving ARB state.
    applyStimulus(mk("t5_lock", 0,0,0,0, 1,1,1,'h300,32'hCAFEF00D, 0,1));
    reset = 1'b1;
    cpu_req = 1; aux_req = 1; aux_lock = 1;
    @(negedge clock);
    checkZero("t5_rst_burst");
    @(posedge clock); #1;
    reset = 1'b0;
    applyStimulus(mk("t5_arb_tie", 1,0,'h300,0, 1,1,1,'h301,32'h0BADF00D, 1,0));
    applyStimulus(mk("t5_end", 0,0,0,0, 0,0,0,0,0, 0,0));
    applyStimulus(mk("t5_end2", 0,0,0,0, 0,0,0,0,0, 0,0));

    checkOutput("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
